// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller for a 10-bit PWM.
// It steps a registered duty word toward a latched target by a fixed step,
// once every DIV PWM frames. Each update is aligned to the frame wrap and
// flagged with a one-cycle load pulse.
module pwm_ramp_ctrl #(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] target,
    input  logic [9:0] step,
    output logic [9:0] data_out,
    output logic       load,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0] PcLast = 10'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StRamp, StFinish} state_e;

    state_e      state_q, state_d;
    logic [9:0]  fc_q, fc_d;
    logic [9:0]  pc_q, pc_d;
    logic [9:0]  tgt_q, tgt_d;
    logic [9:0]  step_q, step_d;
    logic [9:0]  data_q, data_d;
    logic        load_q, load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        frame_end;
    logic [10:0] sum;
    logic [10:0] diff;
    logic [9:0]  upd;

    // Clamped next duty value; the extra bit keeps the sum and difference from wrapping.
    always_comb begin
        sum  = {1'b0, data_q} + {1'b0, step_q};
        diff = {1'b0, data_q} - {1'b0, step_q};
        if (data_q < tgt_q) begin
            upd = (sum >= {1'b0, tgt_q}) ? tgt_q : sum[9:0];
        end else begin
            upd = (diff[10] || (diff[9:0] <= tgt_q)) ? tgt_q : diff[9:0];
        end
    end

    assign frame_end = (fc_q == 10'd1023);

    // Next-state logic for the ramp FSM, frame counters and registered outputs.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q + 10'd1;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        data_d  = data_q;
        load_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (target != data_q) begin
                        tgt_d   = target;
                        step_d  = (step == 10'd0) ? 10'd1 : step;
                        pc_d    = 10'd0;
                        busy_d  = 1'b1;
                        state_d = StRamp;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StRamp: begin
                if (frame_end) begin
                    if (pc_q == PcLast) begin
                        pc_d   = 10'd0;
                        data_d = upd;
                        load_d = 1'b1;
                        if (upd == tgt_q) begin
                            busy_d  = 1'b0;
                            state_d = StFinish;
                        end
                    end else begin
                        pc_d = pc_q + 10'd1;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            fc_q    <= 10'd0;
            pc_q    <= 10'd0;
            tgt_q   <= 10'd0;
            step_q  <= 10'd0;
            data_q  <= 10'd0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            data_q  <= data_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign load     = load_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
